// File: rtl/dac_readback.sv
// ---------------------------------------------------------------------------
// dac_readback
//   Reads BYTES bytes back from eight synchronous-read memory banks (four
//   "odd" and four "even" banks sharing one read-data bus). Each byte is
//   serialised MSB first on si_data. Every byte takes 11 cycles:
//   READ, WAIT, SHIFT x8 and NEXT.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : single-cycle run request (honoured in IDLE and FINISH only)
//   im_datain  : shared 8-bit read data, valid one cycle after a strobe
//   im_addr    : 5-bit word address, held outside READ
//   odd1_rd..odd4_rd, even1_rd..even4_rd : active-low bank read strobes
//   si_data    : serial data bit, MSB first, 0 when si_valid is low
//   si_valid   : high while si_data carries a bit
//   busy       : high from run start until FINISH
//   im_finish  : high in FINISH
//
// BYTES must be 16..256 in steps of 16.
// ---------------------------------------------------------------------------
module dac_readback #(
  parameter int BYTES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] im_datain,
  output logic [4:0] im_addr,
  output logic       odd1_rd,
  output logic       odd2_rd,
  output logic       odd3_rd,
  output logic       odd4_rd,
  output logic       even1_rd,
  output logic       even2_rd,
  output logic       even3_rd,
  output logic       even4_rd,
  output logic       si_data,
  output logic       si_valid,
  output logic       busy,
  output logic       im_finish
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT   = 3'd2,
    SHIFT  = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [8:0] LAST_K = 9'(BYTES - 1);

  // Active-low strobe vector for byte k. Bits 0..3 are odd1..odd4,
  // bits 4..7 are even1..even4. Polarity is even when k[0]^k[3] is set,
  // and k[7:6] picks the bank within the polarity group.
  function automatic logic [7:0] strobe_mask(input logic [8:0] k);
    logic [7:0] m;
    logic [2:0] sel;
    m      = 8'hFF;
    sel    = {k[0] ^ k[3], k[7:6]};
    m[sel] = 1'b0;
    return m;
  endfunction

  state_t      state_q;
  logic [8:0]  k_q;
  logic [8:0]  k_d;
  logic [4:0]  addr_q;
  logic [7:0]  rd_n_q;
  logic [7:0]  rd_n_d;
  logic [7:0]  sh_q;
  logic [2:0]  bit_q;
  logic        si_data_q;
  logic        si_valid_q;
  logic        busy_q;
  logic        finish_q;

  // Byte index (and its strobe pattern) for the READ that would follow now.
  always_comb begin
    k_d = k_q;
    case (state_q)
      IDLE, FINISH: k_d = 9'd0;
      NEXT:         k_d = k_q + 9'd1;
      default:      k_d = k_q;
    endcase
    rd_n_d = strobe_mask(k_d);
  end

  // Readback FSM; all outputs are registered here so none follows an input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= 9'd0;
      addr_q     <= 5'd0;
      rd_n_q     <= 8'hFF;
      sh_q       <= 8'd0;
      bit_q      <= 3'd0;
      si_data_q  <= 1'b0;
      si_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          if (start) begin
            state_q  <= READ;
            k_q      <= k_d;
            addr_q   <= k_d[5:1];
            rd_n_q   <= rd_n_d;
            busy_q   <= 1'b1;
            finish_q <= 1'b0;
          end else begin
            state_q  <= state_q;
          end
        end
        READ: begin
          state_q <= WAIT;
          rd_n_q  <= 8'hFF;
        end
        WAIT: begin
          // Bank data arrives one cycle after the strobe; present bit 7
          // immediately and keep the rest for shifting.
          state_q    <= SHIFT;
          si_data_q  <= im_datain[7];
          sh_q       <= {im_datain[6:0], 1'b0};
          si_valid_q <= 1'b1;
          bit_q      <= 3'd0;
        end
        SHIFT: begin
          if (bit_q == 3'd7) begin
            state_q    <= NEXT;
            si_valid_q <= 1'b0;
            si_data_q  <= 1'b0;
          end else begin
            si_data_q <= sh_q[7];
            sh_q      <= {sh_q[6:0], 1'b0};
            bit_q     <= bit_q + 3'd1;
          end
        end
        NEXT: begin
          if (k_q == LAST_K) begin
            state_q  <= FINISH;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
          end else begin
            state_q <= READ;
            k_q     <= k_d;
            addr_q  <= k_d[5:1];
            rd_n_q  <= rd_n_d;
          end
        end
        default: begin
          state_q    <= IDLE;
          rd_n_q     <= 8'hFF;
          si_valid_q <= 1'b0;
          si_data_q  <= 1'b0;
          busy_q     <= 1'b0;
          finish_q   <= 1'b0;
        end
      endcase
    end
  end

  assign im_addr   = addr_q;
  assign odd1_rd   = rd_n_q[0];
  assign odd2_rd   = rd_n_q[1];
  assign odd3_rd   = rd_n_q[2];
  assign odd4_rd   = rd_n_q[3];
  assign even1_rd  = rd_n_q[4];
  assign even2_rd  = rd_n_q[5];
  assign even3_rd  = rd_n_q[6];
  assign even4_rd  = rd_n_q[7];
  assign si_data   = si_data_q;
  assign si_valid  = si_valid_q;
  assign busy      = busy_q;
  assign im_finish = finish_q;

endmodule

// File: tb/tb_dac_readback.sv
// ---------------------------------------------------------------------------
// tb_dac_readback
//   Scoreboard bench: expected strobe events (bank, address) and serial bits
//   are queued when a run is started; a negedge monitor pops and compares
//   whenever a strobe is low or si_valid is high.
// ---------------------------------------------------------------------------
module tb_dac_readback;
  localparam int BYTES   = 256;
  localparam int RUN_CYC = BYTES * 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] im_datain;
  logic [4:0] im_addr;
  logic       odd1_rd, odd2_rd, odd3_rd, odd4_rd;
  logic       even1_rd, even2_rd, even3_rd, even4_rd;
  logic       si_data, si_valid, busy, im_finish;

  always #5 clk = ~clk;

  dac_readback #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .im_datain(im_datain),
    .im_addr(im_addr),
    .odd1_rd(odd1_rd), .odd2_rd(odd2_rd), .odd3_rd(odd3_rd), .odd4_rd(odd4_rd),
    .even1_rd(even1_rd), .even2_rd(even2_rd), .even3_rd(even3_rd), .even4_rd(even4_rd),
    .si_data(si_data), .si_valid(si_valid), .busy(busy), .im_finish(im_finish)
  );

  logic [7:0] strb;
  assign strb = {even4_rd, even3_rd, even2_rd, even1_rd, odd4_rd, odd3_rd, odd2_rd, odd1_rd};

  // Bank model: banks 0..3 = odd1..odd4, 4..7 = even1..even4; synchronous read.
  logic [7:0] mem [8][32];
  logic [7:0] bank_q = 8'd0;
  assign im_datain = bank_q;

  always @(posedge clk) begin
    for (int b = 0; b < 8; b++)
      if (!strb[b]) bank_q <= mem[b][im_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  int exp_rd[$];
  bit exp_bits[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte k reads from an odd bank when k%2 and (k/8)%2 agree.
  function automatic int ref_bank(input int k);
    int g = (k / 64) % 4;
    bit odd = ((k % 2) == ((k / 8) % 2));
    return odd ? g : 4 + g;
  endfunction

  task automatic push_run();
    for (int k = 0; k < BYTES; k++) begin
      int b = ref_bank(k);
      int a = (k / 2) % 32;
      logic [7:0] d = mem[b][a];
      exp_rd.push_back(b * 32 + a);
      for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int already);
    int cyc = already;
    while (!im_finish && cyc < RUN_CYC + 50) begin
      @(negedge clk);
      cyc++;
    end
    check(name, cyc, RUN_CYC);
    check({name, "_busy"}, busy, 0);
    check({name, "_valid"}, si_valid, 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_bits_left"}, exp_bits.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_strb"}, strb, 255);
    check({name, "_addr"}, im_addr, 0);
    check({name, "_valid"}, si_valid, 0);
    check({name, "_data"}, si_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_finish"}, im_finish, 0);
  endtask

  // Monitor: compare strobe events and serial bits against the queues.
  always @(negedge clk) begin : monitor
    int pos;
    if (mon_en && !rst) begin
      if (strb != 8'hFF) begin
        pos = -1;
        for (int b = 0; b < 8; b++) if (!strb[b]) pos = b;
        check("one_strobe", $countones(~strb), 1);
        if (exp_rd.size() == 0) check("unexpected_strobe", pos * 32 + im_addr, -1);
        else check("strobe_bank_addr", pos * 32 + im_addr, exp_rd.pop_front());
      end
      if (si_valid) begin
        if (exp_bits.size() == 0) check("unexpected_bit", si_data, -1);
        else check("si_data", si_data, exp_bits.pop_front());
      end else begin
        check("si_data_idle_zero", si_data, 0);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 32; a++) mem[b][a] = 8'hA5;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Idle without start.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_strb", strb, 255);
      check("idle_valid", si_valid, 0);
      check("idle_finish", im_finish, 0);
    end

    // Run with every bank returning A5; inspect the first byte closely.
    push_run();
    pulse_start();
    check("a5_odd1_low", odd1_rd, 0);
    check("a5_addr0", im_addr, 0);
    check("a5_busy", busy, 1);
    @(negedge clk);
    check("a5_wait_valid", si_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("a5_shift_valid", si_valid, 1);
    end
    @(negedge clk);
    check("a5_next_valid", si_valid, 0);
    wait_finish("a5_run_len", 10);

    // Content {bank id, addr}: polarity pattern and group switches.
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 32; a++) mem[b][a] = {3'(b), 5'(a)};
    push_run();
    pulse_start();
    wait_finish("id_run_len", 0);

    // Random content, start pulsed during SHIFT of byte 3.
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 32; a++) mem[b][a] = 8'($urandom);
    push_run();
    pulse_start();
    repeat (37) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish("ignore_start_run_len", 38);

    // Random content, reset during WAIT of byte 10.
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 32; a++) mem[b][a] = 8'($urandom);
    push_run();
    pulse_start();
    repeat (111) @(negedge clk);
    check("byte10_wait_strb", strb, 255);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_rd.delete();
    exp_bits.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    push_run();
    pulse_start();
    check("restart_addr0", im_addr, 0);
    check("restart_odd1_low", odd1_rd, 0);
    wait_finish("restart_run_len", 0);

    // Start in FINISH repeats the same run.
    push_run();
    pulse_start();
    check("refinish_drop", im_finish, 0);
    check("refinish_busy", busy, 1);
    wait_finish("repeat_run_len", 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
